// File: rtl/pc_reg_pkg.sv
// Shared constants and types for the program-counter register.
//   PC_WIDTH         width of the program counter and its data ports
//   PC_RESET_VECTOR  address fetched first after reset
//   INSTR_BYTES      size of one instruction; the sequential PC increment
//   pc_t             program-counter value type
package pc_reg_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register for the single-cycle datapath.
// Captures the next-PC value every rising edge and exposes the current PC,
// the sequential successor (PC + 4) and a word-alignment status flag.
// Next-PC selection lives upstream; this block only stores.
//
// Ports:
//   i_clk         system clock, rising-edge
//   i_rst_n       synchronous active-low reset, loads RESET_VALUE
//   i_pc          next-PC value to capture
//   o_pc          current PC, straight from the register
//   o_pc_plus4    o_pc + 4, wraps modulo 2^WIDTH
//   o_misaligned  high when o_pc is not word aligned (status only)
module pc_reg
    import pc_reg_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VECTOR)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_pc,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus4,
    output logic             o_misaligned
);

    logic [WIDTH-1:0] pc_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= i_pc;
        end
    end

    assign o_pc = pc_q;

    // Single shared incrementer; carry out of the top bit is dropped on purpose.
    assign o_pc_plus4 = pc_q + WIDTH'(INSTR_BYTES);

    assign o_misaligned = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_reg.sv
module tb_pc_reg;
    import pc_reg_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    pc_t model_pc;

    pc_reg dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pc         (pc_in),
        .o_pc         (pc_out),
        .o_pc_plus4   (pc_plus4),
        .o_misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs derived from the stored value with plain arithmetic.
    task automatic check_model(input string tag);
        longint unsigned sum;
        logic [31:0] exp_plus4;
        logic [31:0] exp_mis;
        sum = (longint'(model_pc) + 64'd4) % 64'h1_0000_0000;
        exp_plus4 = sum[31:0];
        exp_mis = ((model_pc % 4) != 0) ? 32'd1 : 32'd0;
        check({tag, ".pc"}, pc_out, model_pc);
        check({tag, ".plus4"}, pc_plus4, exp_plus4);
        check({tag, ".mis"}, {31'b0, misaligned}, exp_mis);
    endtask

    // Called at a falling edge: drive, take one rising edge, verify at next falling edge.
    task automatic step(input logic rst, input logic [31:0] nxt, input string tag);
        rst_n = rst;
        pc_in = nxt;
        @(posedge clk);
        model_pc = rst ? nxt : 32'h0000_0000;
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        pc_in = 32'h1234_5678;
        model_pc = '0;
        @(negedge clk);

        step(1'b0, 32'h1234_5678, "reset");
        check("reset_lit.pc", pc_out, 32'h0000_0000);
        check("reset_lit.plus4", pc_plus4, 32'h0000_0004);

        step(1'b1, 32'h1234_5678, "load");
        check("load_lit.plus4", pc_plus4, 32'h1234_567C);

        step(1'b1, 32'hFFFF_FFFF, "all_ones");
        check("all_ones_lit.plus4", pc_plus4, 32'h0000_0003);
        check("all_ones_lit.mis", {31'b0, misaligned}, 32'd1);

        // Reset dropped between edges must not act until the next edge.
        rst_n = 1'b0;
        pc_in = 32'hA5A5_A5A5;
        #2;
        check("midcycle_rst.pc", pc_out, 32'hFFFF_FFFF);
        @(posedge clk);
        model_pc = 32'h0000_0000;
        @(negedge clk);
        check_model("midcycle_rst_after");

        // i_pc changes between edges must not reach o_pc combinationally.
        rst_n = 1'b1;
        pc_in = 32'h0000_1000;
        #1;
        pc_in = 32'h0000_2002;
        #2;
        check("midcycle_pc.pc", pc_out, 32'h0000_0000);
        @(posedge clk);
        model_pc = 32'h0000_2002;
        @(negedge clk);
        check_model("midcycle_pc_after");

        step(1'b1, 32'hFFFF_FFFC, "wrap_fc");
        check("wrap_fc_lit.plus4", pc_plus4, 32'h0000_0000);

        step(1'b1, 32'h0040_0000, "stream0");
        step(1'b1, 32'h0040_0004, "stream1");
        step(1'b1, 32'h0040_0008, "stream2");

        step(1'b0, 32'hDEAD_BEEF, "rstprio0");
        step(1'b0, 32'hDEAD_BEEF, "rstprio1");
        step(1'b1, 32'hDEAD_BEEF, "rst_release");
        check("rst_release_lit.pc", pc_out, 32'hDEAD_BEEF);

        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic [31:0] v;
            r = ($urandom_range(0, 9) != 0);
            v = $urandom;
            case ($urandom_range(0, 3))
                0: v = {v[31:2], 2'b00};
                1: v = 32'hFFFF_FFFC | {30'b0, v[1:0]};
                default: ;
            endcase
            step(r, v, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_reg.md
Name: pc_reg

Overview:
- Program-counter register for the single-cycle MIPS datapath.
- Captures the next-PC value computed by upstream next-PC logic (PC+4, branch or jump mux) on every rising clock edge.
- Presents the current PC to the instruction memory and the PC+4 adder.
- Pure state element: no next-PC selection happens inside this block.

Parameters:
- WIDTH, 32, bit width of the PC and of all data ports.
- RESET_VALUE, 32'h0000_0000, value loaded into the PC by reset.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_pc  input  WIDTH  next-PC value to capture.
- o_pc  output  WIDTH  current PC; the registered value.
- o_pc_plus4  output  WIDTH  o_pc + 4, combinational, modulo 2^WIDTH.
- o_misaligned  output  1  high when o_pc[1:0] != 2'b00, combinational.

Behaviour:
- One clock (i_clk). Reset is synchronous and active-low (i_rst_n). i_rst_n is sampled only at the rising edge of i_clk; there is no asynchronous path.
- At each rising edge of i_clk:
  - If i_rst_n == 0, the PC register loads RESET_VALUE.
  - Otherwise, the PC register loads i_pc.
- No enable or stall: the register loads on every cycle when reset is not asserted.
- Latency is one cycle. A value on i_pc at rising edge N appears on o_pc just after edge N and holds until edge N+1.
- o_pc is driven directly from the register. There is no combinational path from i_pc to o_pc.
- Reset value: after any rising edge with i_rst_n low, o_pc = RESET_VALUE (0x0000_0000). With the defaults, o_pc_plus4 = 0x0000_0004 and o_misaligned = 0 at that point.
- Before the first rising edge, o_pc is undefined. The design must not depend on a power-on value. Reset must be applied for at least one edge.
- Reset asserted mid-operation: takes effect at the next rising edge. Whatever i_pc holds at that edge is discarded.
- Reset deasserted: the first edge with i_rst_n high loads i_pc. There is no extra bubble cycle.
- No value transformation on capture. All WIDTH bits are stored verbatim, including all-ones (0xFFFF_FFFF) and misaligned values.
- o_pc_plus4 wraps: 0xFFFF_FFFC + 4 = 0x0000_0000 and 0xFFFF_FFFF + 4 = 0x0000_0003. No carry output.
- o_misaligned is a status flag only. It does not alter the stored PC.

Decomposition:
- Shared package holds:
  - PC_WIDTH = 32.
  - PC_RESET_VECTOR = 32'h0000_0000.
  - INSTR_BYTES = 4 (increment used for o_pc_plus4).
  - typedef pc_t = logic [PC_WIDTH-1:0].
- No sub-module. The block is a single flop array plus an adder and a two-bit compare.
- Keep the PC+4 adder local here so the instruction-fetch and next-PC logic share one copy.

Test Plan:
- Reset: i_pc = 0x1234_5678, i_rst_n = 0 across one rising edge -> at the following falling edge, o_pc = 0x0000_0000, o_pc_plus4 = 0x0000_0004, o_misaligned = 0.
- Load after reset: i_rst_n = 1, i_pc = 0x1234_5678, one rising edge -> o_pc = 0x1234_5678, o_pc_plus4 = 0x1234_567C, o_misaligned = 0.
- All-ones: i_pc = 0xFFFF_FFFF, one rising edge -> o_pc = 0xFFFF_FFFF, o_pc_plus4 = 0x0000_0003 (wrap), o_misaligned = 1.
- Synchronous-reset check: with o_pc = 0xFFFF_FFFF, drop i_rst_n mid-cycle (between edges) -> o_pc unchanged until the next rising edge, then 0x0000_0000. Also change i_pc between edges -> o_pc unchanged until the edge.
- Sequential stream: with i_rst_n = 1, drive i_pc = 0x0040_0000, 0x0040_0004, 0x0040_0008 on consecutive cycles -> o_pc follows each value exactly one cycle later with no gaps.
- Reset priority: i_rst_n = 0 while i_pc = 0xDEAD_BEEF for two edges -> o_pc = 0x0000_0000 after both edges. Release reset -> the next edge loads 0xDEAD_BEEF.
